// File: rtl/uart_rx_pkg.sv
// Shared types and frame constants for the UART receiver control path.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    VALID
  } state_t;

  localparam int DATA_BITS     = 8;
  localparam int START_IDX     = 0;
  localparam int LAST_DATA_IDX = 8;

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Control/status bundle between the RX FSM and its counter, sampler, deserializer and checkers.
interface uart_rx_fsm_if #(
  parameter int Prescale_width = 6,
  parameter int n_bits         = 4
);
  logic                      RX_IN;
  logic                      PAR_EN;
  logic [Prescale_width-1:0] Prescale;
  logic [Prescale_width-1:0] edge_cnt;
  logic [n_bits-1:0]         bit_cnt;
  logic                      strt_glitch;
  logic                      par_err;
  logic                      stp_err;
  logic                      enable;
  logic                      dat_samp_en;
  logic                      strt_chk_en;
  logic                      par_chk_en;
  logic                      stp_chk_en;
  logic                      deser_en;
  logic                      data_valid;

  modport master (
    output RX_IN, PAR_EN, Prescale, edge_cnt, bit_cnt, strt_glitch, par_err, stp_err,
    input  enable, dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en, data_valid
  );

  modport slave (
    input  RX_IN, PAR_EN, Prescale, edge_cnt, bit_cnt, strt_glitch, par_err, stp_err,
    output enable, dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en, data_valid
  );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART receiver frame sequencer: start, data, optional parity and stop phases,
// driven by the external edge/bit counter.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int Prescale_width = 6,
  parameter int n_bits         = 4
) (
  input logic         clk,
  input logic         reset,
  uart_rx_fsm_if.slave bus
);

  state_t                    state;
  state_t                    next_state;
  logic                      bit_end;
  logic                      last_data;
  logic [Prescale_width-1:0] last_edge;

  assign last_edge = bus.Prescale - Prescale_width'(1);
  assign bit_end   = (bus.edge_cnt == last_edge);
  assign last_data = (bus.bit_cnt == n_bits'(LAST_DATA_IDX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state      = state;
    bus.enable      = 1'b0;
    bus.dat_samp_en = 1'b0;
    bus.strt_chk_en = 1'b0;
    bus.par_chk_en  = 1'b0;
    bus.stp_chk_en  = 1'b0;
    bus.deser_en    = 1'b0;
    bus.data_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!bus.RX_IN) next_state = START;
      end
      START: begin
        bus.enable      = 1'b1;
        bus.dat_samp_en = 1'b1;
        bus.strt_chk_en = 1'b1;
        if (bit_end) next_state = bus.strt_glitch ? IDLE : DATA;
      end
      DATA: begin
        bus.enable      = 1'b1;
        bus.dat_samp_en = 1'b1;
        bus.deser_en    = bit_end;
        if (bit_end && last_data) next_state = bus.PAR_EN ? PARITY : STOP;
      end
      PARITY: begin
        bus.enable      = 1'b1;
        bus.dat_samp_en = 1'b1;
        bus.par_chk_en  = 1'b1;
        if (bit_end) next_state = bus.par_err ? IDLE : STOP;
      end
      STOP: begin
        bus.enable      = 1'b1;
        bus.dat_samp_en = 1'b1;
        bus.stp_chk_en  = 1'b1;
        if (bit_end) next_state = bus.stp_err ? IDLE : VALID;
      end
      VALID: begin
        // enable drops here so the counter restarts from 0 for a back-to-back START
        bus.data_valid = 1'b1;
        next_state     = bus.RX_IN ? IDLE : START;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm with Prescale=8 and a modelled edge/bit counter.
module tb_uart_rx_fsm;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  uart_rx_fsm_if #(.Prescale_width(6), .n_bits(4)) bus ();

  uart_rx_fsm #(.Prescale_width(6), .n_bits(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Edge/bit counter: clears whenever enable is low, wraps edge_cnt at Prescale-1.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.edge_cnt <= '0;
      bus.bit_cnt  <= '0;
    end else if (!bus.enable) begin
      bus.edge_cnt <= '0;
      bus.bit_cnt  <= '0;
    end else if (bus.edge_cnt == 6'd7) begin
      bus.edge_cnt <= '0;
      bus.bit_cnt  <= bus.bit_cnt + 4'd1;
    end else begin
      bus.edge_cnt <= bus.edge_cnt + 6'd1;
    end
  end

  int n_en, n_samp, n_strt, n_par, n_stp, n_deser, n_valid;
  int bad_deser, first_par, first_stp, first_valid, second_valid;

  function automatic logic [6:0] outs();
    return {bus.enable, bus.dat_samp_en, bus.strt_chk_en, bus.par_chk_en,
            bus.stp_chk_en, bus.deser_en, bus.data_valid};
  endfunction

  task automatic drive_errs(input logic glitch, input logic perr, input logic serr,
                            input logic noise);
    bus.strt_glitch = glitch | (noise && bus.bit_cnt >= 4'd1);
    bus.par_err     = perr | (noise && bus.bit_cnt < 4'd9);
    bus.stp_err     = serr | (noise && bus.bit_cnt < 4'd9);
  endtask

  // Drops RX_IN for one cycle and records output activity per cycle (k = cycles since the fall).
  task automatic run_frame(input logic pe, input logic glitch, input logic perr,
                           input logic serr, input logic noise, input logic b2b,
                           input int ncyc);
    n_en = 0; n_samp = 0; n_strt = 0; n_par = 0; n_stp = 0; n_deser = 0; n_valid = 0;
    bad_deser = 0; first_par = -1; first_stp = -1; first_valid = -1; second_valid = -1;
    @(negedge clk);
    bus.PAR_EN = pe;
    drive_errs(glitch, perr, serr, noise);
    bus.RX_IN = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (bus.enable)      n_en++;
      if (bus.dat_samp_en) n_samp++;
      if (bus.strt_chk_en) n_strt++;
      if (bus.par_chk_en) begin
        n_par++;
        if (first_par < 0) first_par = k;
      end
      if (bus.stp_chk_en) begin
        n_stp++;
        if (first_stp < 0) first_stp = k;
      end
      if (bus.deser_en) begin
        n_deser++;
        if (bus.edge_cnt != 6'd7) bad_deser++;
      end
      if (bus.data_valid) begin
        n_valid++;
        if (n_valid == 1) first_valid = k;
        else if (n_valid == 2) second_valid = k;
      end
      drive_errs(glitch, perr, serr, noise);
      bus.RX_IN = (b2b && bus.data_valid && n_valid == 1) ? 1'b0 : 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if (outs() !== 7'b0) begin
      errors++;
      $display("FAIL reset_outs: got %b expected %b", outs(), 7'b0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (outs() !== 7'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected %b", outs(), 7'b0);
    end
  endtask

  task automatic test_valid_parity();
    run_frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 100);
    checks++; if (n_deser !== 8) begin errors++; $display("FAIL vp_deser_cnt: got %0d expected 8", n_deser); end
    checks++; if (bad_deser !== 0) begin errors++; $display("FAIL vp_deser_edge: got %0d expected 0", bad_deser); end
    checks++; if (n_strt !== 8) begin errors++; $display("FAIL vp_strt_cnt: got %0d expected 8", n_strt); end
    checks++; if (n_par !== 8) begin errors++; $display("FAIL vp_par_cnt: got %0d expected 8", n_par); end
    checks++; if (first_par !== 73) begin errors++; $display("FAIL vp_par_start: got %0d expected 73", first_par); end
    checks++; if (n_stp !== 8) begin errors++; $display("FAIL vp_stp_cnt: got %0d expected 8", n_stp); end
    checks++; if (first_stp !== 81) begin errors++; $display("FAIL vp_stp_start: got %0d expected 81", first_stp); end
    checks++; if (n_en !== 88) begin errors++; $display("FAIL vp_enable_cnt: got %0d expected 88", n_en); end
    checks++; if (n_samp !== 88) begin errors++; $display("FAIL vp_samp_cnt: got %0d expected 88", n_samp); end
    checks++; if (n_valid !== 1) begin errors++; $display("FAIL vp_valid_cnt: got %0d expected 1", n_valid); end
    checks++; if (first_valid !== 89) begin errors++; $display("FAIL vp_valid_time: got %0d expected 89", first_valid); end
    checks++; if (outs() !== 7'b0) begin errors++; $display("FAIL vp_end_idle: got %b expected %b", outs(), 7'b0); end
  endtask

  task automatic test_no_parity();
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 100);
    checks++; if (n_par !== 0) begin errors++; $display("FAIL np_par_cnt: got %0d expected 0", n_par); end
    checks++; if (first_stp !== 73) begin errors++; $display("FAIL np_stp_start: got %0d expected 73", first_stp); end
    checks++; if (first_valid !== 81) begin errors++; $display("FAIL np_valid_time: got %0d expected 81", first_valid); end
    checks++; if (n_valid !== 1) begin errors++; $display("FAIL np_valid_cnt: got %0d expected 1", n_valid); end
  endtask

  task automatic test_start_glitch();
    run_frame(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 100);
    checks++; if (n_strt !== 8) begin errors++; $display("FAIL gl_strt_cnt: got %0d expected 8", n_strt); end
    checks++; if (n_en !== 8) begin errors++; $display("FAIL gl_enable_cnt: got %0d expected 8", n_en); end
    checks++; if (n_deser !== 0) begin errors++; $display("FAIL gl_deser_cnt: got %0d expected 0", n_deser); end
    checks++; if (n_valid !== 0) begin errors++; $display("FAIL gl_valid_cnt: got %0d expected 0", n_valid); end
    checks++; if (outs() !== 7'b0) begin errors++; $display("FAIL gl_end_idle: got %b expected %b", outs(), 7'b0); end
  endtask

  task automatic test_stop_error();
    run_frame(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 100);
    checks++; if (n_par !== 0) begin errors++; $display("FAIL se_par_cnt: got %0d expected 0", n_par); end
    checks++; if (n_stp !== 8) begin errors++; $display("FAIL se_stp_cnt: got %0d expected 8", n_stp); end
    checks++; if (n_valid !== 0) begin errors++; $display("FAIL se_valid_cnt: got %0d expected 0", n_valid); end
    checks++; if (n_en !== 80) begin errors++; $display("FAIL se_enable_cnt: got %0d expected 80", n_en); end
    checks++; if (outs() !== 7'b0) begin errors++; $display("FAIL se_end_idle: got %b expected %b", outs(), 7'b0); end
  endtask

  task automatic test_parity_error();
    run_frame(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 100);
    checks++; if (n_deser !== 8) begin errors++; $display("FAIL pe_deser_cnt: got %0d expected 8", n_deser); end
    checks++; if (n_par !== 8) begin errors++; $display("FAIL pe_par_cnt: got %0d expected 8", n_par); end
    checks++; if (n_stp !== 0) begin errors++; $display("FAIL pe_stp_cnt: got %0d expected 0", n_stp); end
    checks++; if (n_valid !== 0) begin errors++; $display("FAIL pe_valid_cnt: got %0d expected 0", n_valid); end
    checks++; if (outs() !== 7'b0) begin errors++; $display("FAIL pe_end_idle: got %b expected %b", outs(), 7'b0); end
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    bus.PAR_EN = 1'b1;
    drive_errs(1'b0, 1'b0, 1'b0, 1'b0);
    bus.RX_IN = 1'b0;
    @(negedge clk);
    bus.RX_IN = 1'b1;
    repeat (29) @(negedge clk);
    checks++;
    if (bus.enable !== 1'b1) begin
      errors++;
      $display("FAIL rm_in_frame_enable: got %b expected 1", bus.enable);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (outs() !== 7'b0) begin
      errors++;
      $display("FAIL rm_outs_at_reset: got %b expected %b", outs(), 7'b0);
    end
    @(negedge clk);
    reset = 1'b0;
    run_frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 100);
    checks++; if (first_valid !== 89) begin errors++; $display("FAIL rm_next_valid_time: got %0d expected 89", first_valid); end
    checks++; if (n_valid !== 1) begin errors++; $display("FAIL rm_next_valid_cnt: got %0d expected 1", n_valid); end
  endtask

  task automatic test_back_to_back();
    run_frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 190);
    checks++; if (n_valid !== 2) begin errors++; $display("FAIL bb_valid_cnt: got %0d expected 2", n_valid); end
    checks++; if (first_valid !== 89) begin errors++; $display("FAIL bb_first_valid: got %0d expected 89", first_valid); end
    checks++; if (second_valid !== 178) begin errors++; $display("FAIL bb_second_valid: got %0d expected 178", second_valid); end
    checks++; if (n_deser !== 16) begin errors++; $display("FAIL bb_deser_cnt: got %0d expected 16", n_deser); end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    bus.RX_IN       = 1'b1;
    bus.PAR_EN      = 1'b0;
    bus.Prescale    = 6'd8;
    bus.strt_glitch = 1'b0;
    bus.par_err     = 1'b0;
    bus.stp_err     = 1'b0;
    test_reset();
    test_valid_parity();
    test_no_parity();
    test_start_glitch();
    test_stop_error();
    test_parity_error();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
